// File: rtl/float_copro_if.sv
// UDI request/response and float-datapath bus for float_copro_ctrl.
// The controller takes the slave modport; the CPU/datapath side takes master.
interface float_copro_if #(
    parameter int unsigned CNT_W = 16
);
    logic             user_valid_i;
    logic [10:0]      user_opcode_i;
    logic [31:0]      user_op0_i;
    logic [31:0]      user_op1_i;
    logic             user_complete_o;
    logic [31:0]      user_result_o;
    logic [10:0]      dp_opcode_o;
    logic [31:0]      dp_op0_o;
    logic [31:0]      dp_op1_o;
    logic [31:0]      dp_result_i;
    logic             busy_o;
    logic             illegal_o;
    logic             illegal_clr_i;
    logic [CNT_W-1:0] ops_count_o;

    modport slave (
        input  user_valid_i, user_opcode_i, user_op0_i, user_op1_i,
        input  dp_result_i, illegal_clr_i,
        output user_complete_o, user_result_o, dp_opcode_o, dp_op0_o, dp_op1_o,
        output busy_o, illegal_o, ops_count_o
    );

    modport master (
        output user_valid_i, user_opcode_i, user_op0_i, user_op1_i,
        output dp_result_i, illegal_clr_i,
        input  user_complete_o, user_result_o, dp_opcode_o, dp_op0_o, dp_op1_o,
        input  busy_o, illegal_o, ops_count_o
    );
endinterface

// File: rtl/float_copro_ctrl.sv
// Sequencer between the LM32 UDI port and a combinational float datapath run as a multicycle path.
// Optional feature: define FLOAT_COPRO_STATS_EN for a saturating completed-operation counter.
module float_copro_ctrl #(
    parameter int unsigned LATENCY = 2,
    parameter int unsigned CNT_W   = 16
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    float_copro_if.slave  bus
);
    localparam int unsigned LAT_W  = 4;
    localparam int unsigned OPC_W  = 11;
    localparam int unsigned DATA_W = 32;
    localparam logic [OPC_W-1:0] OPC_MAX = OPC_W'(2);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;

    state_e              state_q, state_d;
    logic [LAT_W-1:0]    lat_cnt_q, lat_cnt_d;
    logic                valid_q, valid_d;
    logic [OPC_W-1:0]    dp_opcode_q, dp_opcode_d;
    logic [DATA_W-1:0]   dp_op0_q, dp_op0_d;
    logic [DATA_W-1:0]   dp_op1_q, dp_op1_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                illegal_q, illegal_d;
    logic                complete_q, complete_d;
    logic                busy_q, busy_d;
    logic                accept;
    logic                illegal_set;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            lat_cnt_q   <= '0;
            valid_q     <= 1'b0;
            dp_opcode_q <= '0;
            dp_op0_q    <= '0;
            dp_op1_q    <= '0;
            result_q    <= '0;
            illegal_q   <= 1'b0;
            complete_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            lat_cnt_q   <= lat_cnt_d;
            valid_q     <= valid_d;
            dp_opcode_q <= dp_opcode_d;
            dp_op0_q    <= dp_op0_d;
            dp_op1_q    <= dp_op1_d;
            result_q    <= result_d;
            illegal_q   <= illegal_d;
            complete_q  <= complete_d;
            busy_q      <= busy_d;
        end
    end

    // Only a rising request edge in IDLE starts work; a level held past completion is ignored.
    always_comb begin
        state_d     = state_q;
        lat_cnt_d   = lat_cnt_q;
        valid_d     = bus.user_valid_i;
        dp_opcode_d = dp_opcode_q;
        dp_op0_d    = dp_op0_q;
        dp_op1_d    = dp_op1_q;
        result_d    = result_q;
        illegal_set = 1'b0;
        accept      = (state_q == IDLE) && bus.user_valid_i && !valid_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (bus.user_opcode_i <= OPC_MAX) begin
                        dp_opcode_d = bus.user_opcode_i;
                        dp_op0_d    = bus.user_op0_i;
                        dp_op1_d    = bus.user_op1_i;
                        lat_cnt_d   = LAT_W'(LATENCY - 1);
                        state_d     = EXEC;
                    end else begin
                        result_d    = '0;
                        illegal_set = 1'b1;
                        state_d     = DONE;
                    end
                end
            end
            EXEC: begin
                if (lat_cnt_q != '0) begin
                    lat_cnt_d = lat_cnt_q - LAT_W'(1);
                end else begin
                    result_d = bus.dp_result_i;
                    state_d  = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Set wins over a simultaneous clear.
        illegal_d  = illegal_set | (illegal_q & ~bus.illegal_clr_i);
        complete_d = (state_d == DONE);
        busy_d     = (state_d != IDLE);
    end

    assign bus.user_complete_o = complete_q;
    assign bus.user_result_o   = result_q;
    assign bus.dp_opcode_o     = dp_opcode_q;
    assign bus.dp_op0_o        = dp_op0_q;
    assign bus.dp_op1_o        = dp_op1_q;
    assign bus.busy_o          = busy_q;
    assign bus.illegal_o       = illegal_q;

`ifdef FLOAT_COPRO_STATS_EN
    logic             done_legal_q, done_legal_d;
    logic [CNT_W-1:0] ops_count_q, ops_count_d;

    // done_legal_q marks a DONE cycle reached through EXEC, i.e. a legal opcode.
    always_comb begin
        done_legal_d = (state_q == EXEC) && (lat_cnt_q == '0);
        ops_count_d  = ops_count_q;
        if (done_legal_q && (ops_count_q != '1)) begin
            ops_count_d = ops_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            done_legal_q <= 1'b0;
            ops_count_q  <= '0;
        end else begin
            done_legal_q <= done_legal_d;
            ops_count_q  <= ops_count_d;
        end
    end

    assign bus.ops_count_o = ops_count_q;
`else
    assign bus.ops_count_o = CNT_W'(0);
`endif
endmodule

// File: tb/tb_float_copro_ctrl.sv
// Self-checking bench for float_copro_ctrl: directed cases plus randomized requests against a
// transaction-level model; a datapath stand-in only yields its true result once inputs have settled.
module tb_float_copro_ctrl;
    localparam int unsigned LAT = 2;
    localparam int unsigned CW  = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    float_copro_if #(.CNT_W(CW)) bus();

    float_copro_ctrl #(.LATENCY(LAT), .CNT_W(CW)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Datapath stand-in: known float vectors, otherwise a deterministic mix.
    function automatic logic [31:0] dp_fn(input logic [10:0] opc, input logic [31:0] a,
                                          input logic [31:0] b);
        if (opc == 11'd0 && a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
        if (opc == 11'd1 && a == 32'h4040_0000 && b == 32'h3F80_0000) return 32'h4000_0000;
        if (opc == 11'd2 && a == 32'h3FC0_0000 && b == 32'h4000_0000) return 32'h4040_0000;
        return (a ^ {b[15:0], b[31:16]}) + 32'(opc) * 32'h9E37_79B9;
    endfunction

    // Output is wrong until the datapath inputs have been stable for LAT cycles.
    logic [10:0] seen_opc = '0;
    logic [31:0] seen_op0 = '0;
    logic [31:0] seen_op1 = '0;
    int          stab     = 0;
    always @(negedge clk) begin
        if (bus.dp_opcode_o !== seen_opc || bus.dp_op0_o !== seen_op0 || bus.dp_op1_o !== seen_op1)
            stab = 1;
        else if (stab < 100)
            stab++;
        seen_opc = bus.dp_opcode_o;
        seen_op0 = bus.dp_op0_o;
        seen_op1 = bus.dp_op1_o;
        bus.dp_result_i = (stab >= int'(LAT)) ? dp_fn(seen_opc, seen_op0, seen_op1)
                                              : ~dp_fn(seen_opc, seen_op0, seen_op1);
    end

    // Transaction-level reference state.
    logic [10:0] m_opc     = '0;
    logic [31:0] m_op0     = '0;
    logic [31:0] m_op1     = '0;
    logic [31:0] m_result  = '0;
    logic        m_illegal = 1'b0;
    int unsigned m_count   = 0;

    function automatic logic [31:0] exp_count();
`ifdef FLOAT_COPRO_STATS_EN
        return 32'(m_count);
`else
        return 32'd0;
`endif
    endfunction

    // Issue one request at a negedge; returns at a negedge with valid low again.
    task automatic issue(input logic [10:0] opc, input logic [31:0] a, input logic [31:0] b,
                         input bit clr, input int hold, input int gap);
        bit legal;
        int exp_lat;
        int seen;
        int extra;
        legal   = (opc <= 11'd2);
        exp_lat = legal ? int'(LAT) + 1 : 1;
        seen    = 0;
        extra   = 0;
        bus.user_valid_i  = 1'b1;
        bus.user_opcode_i = opc;
        bus.user_op0_i    = a;
        bus.user_op1_i    = b;
        bus.illegal_clr_i = clr;
        if (legal) begin
            m_opc = opc; m_op0 = a; m_op1 = b;
            m_result = dp_fn(opc, a, b);
            if (clr) m_illegal = 1'b0;
            if (m_count < (32'd1 << CW) - 1) m_count++;
        end else begin
            m_result  = '0;
            m_illegal = 1'b1;
        end
        for (int i = 1; i <= int'(LAT) + 8 && seen == 0; i++) begin
            @(negedge clk);
            bus.illegal_clr_i = 1'b0;
            if (bus.user_complete_o === 1'b1) seen = i;
            else if (legal && i < exp_lat) check_eq("dp_op0_hold", bus.dp_op0_o, a);
        end
        check_eq("complete_lat", 32'(seen), 32'(exp_lat));
        check_eq("result", bus.user_result_o, m_result);
        check_eq("illegal", 32'(bus.illegal_o), 32'(m_illegal));
        check_eq("busy_done", 32'(bus.busy_o), 32'd1);
        check_eq("dp_opcode", 32'(bus.dp_opcode_o), 32'(m_opc));
        check_eq("dp_op1", bus.dp_op1_o, m_op1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (bus.user_complete_o === 1'b1) extra++;
        end
        bus.user_valid_i = 1'b0;
        for (int i = 0; i < gap; i++) begin
            @(negedge clk);
            if (bus.user_complete_o === 1'b1) extra++;
        end
        check_eq("extra_complete", 32'(extra), 32'd0);
        check_eq("busy_idle", 32'(bus.busy_o), 32'd0);
        check_eq("ops_count", 32'(bus.ops_count_o), exp_count());
    endtask

    task automatic clear_illegal();
        bus.illegal_clr_i = 1'b1;
        @(negedge clk);
        bus.illegal_clr_i = 1'b0;
        m_illegal = 1'b0;
        check_eq("illegal_clr", 32'(bus.illegal_o), 32'd0);
    endtask

    initial begin
        int extra;
        logic [10:0] opc;
        bus.user_valid_i  = 1'b0;
        bus.user_opcode_i = '0;
        bus.user_op0_i    = '0;
        bus.user_op1_i    = '0;
        bus.illegal_clr_i = 1'b0;
        bus.dp_result_i   = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_complete", 32'(bus.user_complete_o), 32'd0);
        check_eq("rst_result", bus.user_result_o, 32'd0);
        check_eq("rst_busy", 32'(bus.busy_o), 32'd0);
        check_eq("rst_illegal", 32'(bus.illegal_o), 32'd0);
        check_eq("rst_dp_op0", bus.dp_op0_o, 32'd0);
        check_eq("rst_count", 32'(bus.ops_count_o), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(11'd0, 32'h3F80_0000, 32'h4000_0000, 1'b0, 0, 1);
        issue(11'd1, 32'h4040_0000, 32'h3F80_0000, 1'b0, 0, 1);
        issue(11'd2, 32'h3FC0_0000, 32'h4000_0000, 1'b0, 0, 1);
        issue(11'd5, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 0, 1);
        clear_illegal();
        issue(11'd0, 32'h3F80_0000, 32'h4000_0000, 1'b0, 10, 1);
        issue(11'd7, 32'h0BAD_F00D, 32'h0000_0001, 1'b1, 0, 1);
        clear_illegal();

        // Asynchronous reset in the EXEC cycle right after accept.
        bus.user_valid_i  = 1'b1;
        bus.user_opcode_i = 11'd0;
        bus.user_op0_i    = 32'h4110_0000;
        bus.user_op1_i    = 32'h4120_0000;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_complete", 32'(bus.user_complete_o), 32'd0);
        check_eq("arst_busy", 32'(bus.busy_o), 32'd0);
        check_eq("arst_result", bus.user_result_o, 32'd0);
        check_eq("arst_dp_op0", bus.dp_op0_o, 32'd0);
        check_eq("arst_count", 32'(bus.ops_count_o), 32'd0);
        m_opc = '0; m_op0 = '0; m_op1 = '0; m_result = '0; m_illegal = 1'b0; m_count = 0;
        bus.user_valid_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.user_complete_o === 1'b1) extra++;
        end
        check_eq("arst_no_complete", 32'(extra), 32'd0);
        issue(11'd1, 32'h4040_0000, 32'h3F80_0000, 1'b0, 0, 1);

        for (int n = 0; n < 40; n++) begin
            opc = ($urandom_range(0, 4) <= 2) ? 11'($urandom_range(0, 2))
                                              : 11'($urandom_range(3, 2047));
            issue(opc, $urandom, $urandom, ($urandom_range(0, 3) == 0),
                  int'($urandom_range(0, 3)), int'($urandom_range(1, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
